// File: rtl/music_cpu_pkg.sv
// music_cpu_pkg: bitmap transfer sizing and controller state encoding shared
// by the bitmap load/store datapath.
package music_cpu_pkg;
    localparam int BM_WIDTH   = 1536;
    localparam int WORD_WIDTH = 16;
    localparam int BM_BEATS   = BM_WIDTH / WORD_WIDTH;
    localparam int BEAT_CNT_W = 7;
    typedef enum logic [2:0] {IDLE, CAP, WR, RD, WB, DONE} xfer_state_t;
endpackage

// File: rtl/bm_beat_buf.sv
// bm_beat_buf: bitmap-wide staging buffer with parallel load and word-slice access.
module bm_beat_buf #(
    parameter int BM_WIDTH   = music_cpu_pkg::BM_WIDTH,
    parameter int WORD_WIDTH = music_cpu_pkg::WORD_WIDTH,
    parameter int IDX_W      = music_cpu_pkg::BEAT_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BM_WIDTH-1:0]   load_data,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      idx,
    input  logic [WORD_WIDTH-1:0] wr_data,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic [BM_WIDTH-1:0]   q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= load_data;
        else if (wr_en)
            q[idx*WORD_WIDTH +: WORD_WIDTH] <= wr_data;
    end
    assign rd_data = q[idx*WORD_WIDTH +: WORD_WIDTH];
endmodule

// File: rtl/bm_xfer_ctrl.sv
// bm_xfer_ctrl: moves a whole bitmap register to/from data memory one word per
// beat (STB / LDB), freezing the pipeline for the duration.
module bm_xfer_ctrl #(
    parameter int BM_WIDTH   = music_cpu_pkg::BM_WIDTH,
    parameter int WORD_WIDTH = music_cpu_pkg::WORD_WIDTH,
    parameter int BM_BEATS   = music_cpu_pkg::BM_BEATS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  is_store,
    input  logic [1:0]            bm_sel,
    input  logic [15:0]           base_addr,
    output logic [1:0]            rbm_addr,
    input  logic [BM_WIDTH-1:0]   rbm_data,
    output logic [1:0]            wbm_addr,
    output logic [BM_WIDTH-1:0]   wbm_data,
    output logic                  wbm,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [15:0]           mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  stall,
    output logic                  done
);
    import music_cpu_pkg::*;

    xfer_state_t           state;
    logic [BEAT_CNT_W-1:0] cnt;
    logic [1:0]            sel_q;
    logic [15:0]           base_q;
    logic                  last;

    assign last      = cnt == BEAT_CNT_W'(BM_BEATS - 1);
    assign mem_addr  = base_q + 16'(cnt);
    assign rbm_addr  = sel_q;
    assign wbm_addr  = sel_q;
    assign stall     = (state inside {CAP, WR, RD, WB}) || (state == IDLE && start);

    bm_beat_buf #(
        .BM_WIDTH  (BM_WIDTH),
        .WORD_WIDTH(WORD_WIDTH),
        .IDX_W     (BEAT_CNT_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (state == CAP),
        .load_data(rbm_data),
        .wr_en    (state == RD && mem_ready),
        .idx      (cnt),
        .wr_data  (mem_rdata),
        .rd_data  (mem_wdata),
        .q        (wbm_data)
    );

    // Strobes are registered: each is set on the edge entering its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sel_q  <= '0;
            base_q <= '0;
            mem_en <= 1'b0;
            mem_wr <= 1'b0;
            wbm    <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state  <= is_store ? CAP : RD;
                    sel_q  <= bm_sel;
                    base_q <= base_addr;
                    cnt    <= '0;
                    mem_en <= !is_store;
                end
                CAP: begin
                    state  <= WR;
                    cnt    <= '0;
                    mem_en <= 1'b1;
                    mem_wr <= 1'b1;
                end
                WR: if (mem_ready) begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        state  <= DONE;
                        mem_en <= 1'b0;
                        mem_wr <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                RD: if (mem_ready) begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        state  <= WB;
                        mem_en <= 1'b0;
                        wbm    <= 1'b1;
                    end
                end
                WB: begin
                    state <= DONE;
                    wbm   <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bm_xfer_ctrl.sv
// tb_bm_xfer_ctrl: scoreboard bench for bitmap store/load transfers, abort and
// ignored-start behaviour.
module tb_bm_xfer_ctrl;
    localparam int EV_WR = 0, EV_WBM = 1, EV_DONE = 2;
    localparam int SN_ZERO = 0, SN_STALL = 1, SN_IDLE = 2;

    typedef struct { int kind; int a; int d; logic [1535:0] bm; } item_t;
    typedef struct { int cyc; int kind; } snap_t;

    logic          clk = 0, rst = 1, start = 0, is_store = 0, mem_ready = 1;
    logic [1:0]    bm_sel = 0;
    logic [15:0]   base_addr = 0;
    logic [1:0]    rbm_addr, wbm_addr;
    logic [1535:0] rbm_data, wbm_data;
    logic          wbm, mem_en, mem_wr, stall, done;
    logic [15:0]   mem_addr, mem_wdata, mem_rdata;

    logic [1535:0] rf [4];
    logic [15:0]   mem [65536];
    item_t         q[$];
    snap_t         sq[$];
    int            cyc = 0, passed = 0, total = 0, stall_cnt = 0, t0 = 0;
    bit            fin = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rbm_data  = rf[rbm_addr];
    assign mem_rdata = mem[mem_addr];

    bm_xfer_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .bm_sel(bm_sel),
        .base_addr(base_addr), .rbm_addr(rbm_addr), .rbm_data(rbm_data),
        .wbm_addr(wbm_addr), .wbm_data(wbm_data), .wbm(wbm), .mem_en(mem_en),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall), .done(done)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic take(input int kind, output item_t it, output bit ok);
        it = '{0, 0, 0, '0};
        ok = 0;
        if (q.size() == 0) chk("event_expected", kind, -1);
        else begin
            it = q.pop_front();
            chk("event_kind", kind, it.kind);
            ok = kind == it.kind;
        end
    endtask

    // Monitor: samples on the falling edge, away from DUT and stimulus updates.
    always @(negedge clk) begin
        item_t it;
        snap_t s;
        bit    ok;
        int    nbad;
        while (sq.size() != 0 && sq[0].cyc <= cyc) begin
            s = sq.pop_front();
            chk("snap_cycle", cyc, s.cyc);
            if (s.kind == SN_ZERO) begin
                chk("zero_ctrl", {mem_en, mem_wr, wbm, done, stall, rbm_addr, wbm_addr}, 0);
                chk("zero_addr_data", {mem_addr, mem_wdata}, 0);
                chk("zero_wbm_data", |wbm_data, 0);
            end else if (s.kind == SN_STALL) chk("stall_start", stall, 1);
            else chk("idle_quiet", {mem_en, wbm, done, stall}, 0);
        end
        if (rst) stall_cnt = 0;
        else begin
            if (mem_en && mem_wr && mem_ready) begin
                take(EV_WR, it, ok);
                if (ok) begin
                    chk("wr_addr", mem_addr, it.a);
                    chk("wr_data", mem_wdata, it.d);
                end
            end
            if (wbm) begin
                take(EV_WBM, it, ok);
                if (ok) begin
                    nbad = 0;
                    for (int k = 0; k < 96; k++)
                        if (wbm_data[16*k +: 16] !== it.bm[16*k +: 16]) nbad++;
                    chk("wbm_addr", wbm_addr, it.a);
                    chk("wbm_bad_slices", nbad, 0);
                end
            end
            if (done) begin
                take(EV_DONE, it, ok);
                if (ok) begin
                    chk("done_cycle", cyc, it.a);
                    chk("done_stall", stall, 0);
                    chk("stall_cycles", stall_cnt, it.d);
                end
                stall_cnt = 0;
            end
            if (stall) stall_cnt++;
        end
        if (fin) begin
            chk("sb_drained", q.size(), 0);
            chk("snaps_drained", sq.size(), 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic go(input logic st, input logic [1:0] sel, input logic [15:0] base);
        idle(1);
        start = 1; is_store = st; bm_sel = sel; base_addr = base; t0 = cyc;
        sq.push_back('{t0, SN_STALL});
        idle(1);
        start = 0; is_store = 0; bm_sel = 0; base_addr = 0;
    endtask

    task automatic stb(input logic [1:0] sel, input logic [15:0] base);
        go(1'b1, sel, base);
        for (int k = 0; k < 96; k++)
            q.push_back('{EV_WR, int'(16'(base + k)), int'(rf[sel][16*k +: 16]), '0});
        q.push_back('{EV_DONE, t0 + 98, 98, '0});
    endtask

    task automatic ldb(input logic [1:0] sel, input logic tog);
        logic [1535:0] exp_bm;
        int lat;
        lat = tog ? 194 : 98;
        go(1'b0, sel, 16'h2000);
        for (int k = 0; k < 96; k++) exp_bm[16*k +: 16] = 16'hA500 + 16'(k);
        q.push_back('{EV_WBM, int'(sel), 0, exp_bm});
        q.push_back('{EV_DONE, t0 + lat, lat, '0});
        if (tog) begin
            for (int i = 0; i < 192; i++) begin
                mem_ready = i[0];
                idle(1);
            end
            mem_ready = 1;
        end
    endtask

    initial begin
        for (int k = 0; k < 96; k++) begin
            rf[0][16*k +: 16] = 16'h5A00 ^ 16'(k);
            rf[1][16*k +: 16] = 16'hC000 + 16'(k);
            rf[2][16*k +: 16] = 16'(k);
            rf[3][16*k +: 16] = 16'h7700 + 16'(2 * k);
        end
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0;
        for (int k = 0; k < 96; k++) mem[16'h2000 + k] = 16'hA500 + 16'(k);
        sq.push_back('{1, SN_ZERO});
        idle(2);
        rst = 0;
        sq.push_back('{cyc, SN_IDLE});
        stb(2'd2, 16'h0100);
        idle(100);
        ldb(2'd1, 1'b1);
        idle(10);
        stb(2'd0, 16'hFFD0);
        idle(100);
        go(1'b0, 2'd1, 16'h2000);
        idle(40);
        rst = 1;
        sq.push_back('{cyc, SN_ZERO});
        idle(1);
        rst = 0;
        idle(2);
        ldb(2'd3, 1'b0);
        idle(100);
        stb(2'd3, 16'h0300);
        idle(11);
        start = 1; is_store = 0; bm_sel = 2'd1; base_addr = 16'h4444;
        idle(1);
        start = 0; bm_sel = 0; base_addr = 0;
        idle(85);
        start = 1; is_store = 0; bm_sel = 2'd1; base_addr = 16'h4444;
        idle(1);
        start = 0; bm_sel = 0; base_addr = 0;
        sq.push_back('{cyc, SN_IDLE});
        idle(2);
        ldb(2'd2, 1'b0);
        idle(100);
        fin = 1;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bm_xfer_ctrl.md
BM_XFER_CTRL -- requirements
Module: bm_xfer_ctrl

Interface
REQ-001 SHALL have parameters: BM_WIDTH, default 1536, bitmap register width; WORD_WIDTH, default 16, data-memory word width; BM_BEATS, default 96, words per bitmap (BM_WIDTH/WORD_WIDTH).
REQ-002 SHALL have ports, clock and reset first (one clock; reset asynchronous, active-high):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request from decode/execute for LDB/STB
- is_store  in  1  1 = STB (bitmap to memory), 0 = LDB (memory to bitmap); sampled with start
- bm_sel  in  2  bitmap register index; sampled with start
- base_addr  in  16  word address of beat 0; sampled with start
- rbm_addr  out  2  bitmap read address to register file
- rbm_data  in  1536  bitmap read data (combinational from register file)
- wbm_addr  out  2  bitmap write address
- wbm_data  out  1536  bitmap write data
- wbm  out  1  bitmap write enable
- mem_en  out  1  data-memory request
- mem_wr  out  1  1 = write beat, 0 = read beat
- mem_addr  out  16  data-memory word address
- mem_wdata  out  16  store beat data
- mem_rdata  in  16  load beat data, valid when mem_ready=1
- mem_ready  in  1  beat accepted/completed this cycle
- stall  out  1  pipeline freeze
- done  out  1  one-cycle completion pulse

Function
REQ-003 SHALL implement FSM states IDLE, CAP, WR, RD, WB, DONE.
REQ-004 IDLE: start=1 with is_store=1 -> CAP; start=1 with is_store=0 -> RD; otherwise stay; bm_sel, base_addr, is_store latched on accepting edge.
REQ-005 CAP: rbm_addr = latched bm_sel; rbm_data captured into internal 1536-bit buffer; beat counter cleared; -> WR.
REQ-006 Beat k (0..95) SHALL cover bitmap bits [16k+15:16k] at mem_addr = base_addr + k, modulo 2^16 (wrap 0xFFFF -> 0x0000).
REQ-007 WR: mem_en=1, mem_wr=1, mem_addr/mem_wdata held stable until a cycle with mem_ready=1; then counter increments; after beat 95 accepted -> DONE.
REQ-008 RD: mem_en=1, mem_wr=0, mem_addr held until mem_ready=1; mem_rdata written into buffer slice k that cycle; after beat 95 -> WB.
REQ-009 WB: wbm=1 for exactly one cycle, wbm_addr = latched bm_sel, wbm_data = buffer; -> DONE.
REQ-010 DONE: done=1 for exactly one cycle; -> IDLE.
REQ-011 stall SHALL be 1 in CAP, WR, RD, WB, and combinationally in IDLE when start=1; 0 in DONE and idle IDLE.
REQ-012 With mem_ready tied 1, done SHALL assert exactly 98 cycles after the start cycle for both LDB and STB; each mem_ready=0 cycle adds one.
REQ-013 start while not in IDLE SHALL be ignored (no queuing); start in the DONE cycle is ignored.
REQ-014 mem_en, wbm, done SHALL be 0 whenever not in their stated states; wbm SHALL never assert during STB.
REQ-015 Beat counter SHALL be 7 bits and never exceed 95.

Reset
REQ-016 rst=1 SHALL asynchronously force IDLE, counter 0, buffer 0, latched fields 0, all outputs 0.
REQ-017 Reset mid-transfer SHALL abort with no wbm pulse and no done; memory words already written remain.

Structure
REQ-018 Shared package music_cpu_pkg SHALL hold BM_WIDTH, WORD_WIDTH, BM_BEATS and the FSM state enum.
REQ-019 One sub-module bm_beat_buf (1536-bit buffer with parallel load, 16-bit slice write and slice read by index) SHALL be instantiated; FSM, counter and address adder stay in bm_xfer_ctrl.

Verification
REQ-020 STB, bm_sel=2, base_addr=0x0100, rbm_data word k = k, mem_ready=1 -> 96 writes, addr 0x0100..0x015F, data 0x0000..0x005F, done at start+98, wbm never 1.
REQ-021 LDB, bm_sel=1, base_addr=0x2000, memory word k = 0xA500+k, mem_ready toggling 1/0 -> single wbm pulse, wbm_addr=1, wbm_data slice k = 0xA500+k, done at start+98+stall count.
REQ-022 STB base_addr=0xFFD0 -> addresses 0xFFD0..0xFFFF then 0x0000..0x002F.
REQ-023 LDB, rst at beat 40 -> all outputs 0 immediately, no wbm, no done; next start runs normally from beat 0.
REQ-024 start pulsed during WR beat 10 and in DONE cycle -> ignored; exactly one done, then a new start accepted in IDLE.
REQ-025 stall check: stall high in the start cycle through the cycle before DONE, low in DONE.
